// File: rtl/position_loader_pkg.sv
// Shared GPU definitions for the sprite position loader: words per sprite,
// attribute slot order inside a sprite, and the loader FSM state encoding.
package position_loader_pkg;

    localparam int SPRITE_WORDS = 6;

    localparam int ATTR_X  = 0;
    localparam int ATTR_Y  = 1;
    localparam int ATTR_TX = 2;
    localparam int ATTR_TY = 3;
    localparam int ATTR_TW = 4;
    localparam int ATTR_TH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } loader_state_e;

endpackage : position_loader_pkg

// File: rtl/position_loader.sv
// Copies count x 6 consecutive memory words into the sprite position register
// bank, one outstanding read at a time, emitting one registered write per word.
module position_loader
    import position_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int INT_WIDTH      = 16,
    parameter int CLUSTER_SIZE   = 20,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [MEM_ADDR_WIDTH-1:0]         base_addr,
    input  logic [$clog2(CLUSTER_SIZE+1)-1:0] count,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_req_addr,
    input  logic                              mem_rsp_valid,
    input  logic [INT_WIDTH-1:0]              mem_rsp_data,
    output logic [ADDR_WIDTH-1:0]             waddr,
    output logic [INT_WIDTH-1:0]              wdata,
    output logic                              wen
);

    localparam int CNT_W     = $clog2(CLUSTER_SIZE + 1);
    localparam int MAX_WORDS = CLUSTER_SIZE * SPRITE_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS + 1);

    loader_state_e             state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          total_q, total_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      mem_req_valid_q, mem_req_valid_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
    logic [INT_WIDTH-1:0]      wdata_q, wdata_d;
    logic                      wen_q, wen_d;

    logic [CNT_W-1:0]          count_clamped;
    logic [IDX_W-1:0]          total_in;
    logic [IDX_W-1:0]          idx_next;

    // Requests beyond the bank capacity are clamped so no write can land past it.
    always_comb begin
        count_clamped = (count > CNT_W'(CLUSTER_SIZE)) ? CNT_W'(CLUSTER_SIZE) : count;
        total_in      = IDX_W'(count_clamped) * IDX_W'(SPRITE_WORDS);
        idx_next      = idx_q + IDX_W'(1);
    end

    // NOTE: every _d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        total_d         = total_q;
        base_d          = base_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        waddr_d         = waddr_q;
        wdata_d         = wdata_q;
        wen_d           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d         = base_addr;
                    total_d        = total_in;
                    idx_d          = '0;
                    mem_req_addr_d = base_addr;
                    if (total_in == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                        busy_d          = 1'b1;
                    end
                end
            end

            REQ: begin
                if (mem_req_ready) begin
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end

            WAIT: begin
                if (mem_rsp_valid) begin
                    wdata_d = mem_rsp_data;
                    waddr_d = ADDR_WIDTH'(idx_q);
                    wen_d   = (idx_q < IDX_W'(MAX_WORDS));
                    idx_d   = idx_next;
                    if (idx_next == total_q) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = base_q + MEM_ADDR_WIDTH'(idx_next);
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous and active-low; non-blocking assignments keep
    // every flop updating from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            total_q         <= '0;
            base_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            waddr_q         <= '0;
            wdata_q         <= '0;
            wen_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            total_q         <= total_d;
            base_q          <= base_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            waddr_q         <= waddr_d;
            wdata_q         <= wdata_d;
            wen_q           <= wen_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign wen           = wen_q;

endmodule : position_loader

// File: tb/tb_position_loader.sv
// Directed bench for position_loader: a memory model answering reads with
// addr ^ 0xA5A5 and a scoreboard of expected bank writes and read addresses.
module tb_position_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [4:0]  count;
    logic        busy;
    logic        done;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        wen;

    position_loader #(
        .ADDR_WIDTH    (16),
        .INT_WIDTH     (16),
        .CLUSTER_SIZE  (20),
        .MEM_ADDR_WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .waddr        (waddr),
        .wdata        (wdata),
        .wen          (wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] waddr;
        logic [15:0] wdata;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] exp_addr[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int done_cnt = 0;
    int req_cnt = 0;

    bit          mem_rand = 1'b1;
    int          stall_cfg = 0;
    int          lat_cfg = 1;
    bit          pend = 1'b0;
    int          rsp_wait = 0;
    int          stall_cnt = 0;
    logic [15:0] pend_addr = '0;
    logic [15:0] held_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_req_addr"}, mem_req_addr, 0);
        check({tag, "_wen"}, wen, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
    endtask

    initial forever @(posedge clk) cyc++;

    // Memory: decides ready/response at each falling edge for the next rising edge.
    initial begin : mem_model
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_rand) begin
                mem_req_ready = 1'($urandom_range(0, 1));
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rsp_data  = 16'($urandom);
            end else begin
                mem_rsp_valid = 1'b0;
                if (pend) begin
                    if (rsp_wait <= 1) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = pend_addr ^ 16'hA5A5;
                        pend          = 1'b0;
                    end else begin
                        rsp_wait--;
                    end
                end
                mem_req_ready = 1'b0;
                if (mem_req_valid === 1'b1 && !pend) begin
                    if (stall_cnt < stall_cfg) begin
                        if (stall_cnt == 0) held_addr = mem_req_addr;
                        else check("req_addr_held", mem_req_addr, held_addr);
                        stall_cnt++;
                    end else begin
                        if (stall_cnt > 0) check("req_addr_held", mem_req_addr, held_addr);
                        mem_req_ready = 1'b1;
                        pend          = 1'b1;
                        pend_addr     = mem_req_addr;
                        rsp_wait      = lat_cfg;
                        stall_cnt     = 0;
                        if (exp_addr.size() == 0) check("req_unexpected", 1, 0);
                        else check("req_addr", mem_req_addr, exp_addr.pop_front());
                    end
                end else if (stall_cnt > 0) begin
                    check("req_valid_held", mem_req_valid, 1);
                    stall_cnt = 0;
                end
            end
        end
    end

    // Write monitor: every wen pops one scoreboard entry.
    initial begin : wr_monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_req_valid === 1'b1) req_cnt++;
            if (done === 1'b1) done_cnt++;
            if (wen === 1'b1) begin
                wen_cnt++;
                check("waddr_range", 32'(waddr < 16'd120), 1);
                if (sb.size() == 0) begin
                    check("wen_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("waddr", waddr, e.waddr);
                    check("wdata", wdata, e.wdata);
                end
            end
        end
    end

    task automatic push_expected(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{waddr: 16'(i), wdata: (b + 16'(i)) ^ 16'hA5A5});
            exp_addr.push_back(b + 16'(i));
        end
    endtask

    task automatic run_load(input logic [15:0] b, input logic [4:0] c, input int s,
                            input int l, input bit glitch);
        int  n;
        int  t0;
        int  w0;
        int  d0;
        int  r0;
        bit  seen;
        n = ((c > 5'd20) ? 20 : int'(c)) * 6;
        stall_cfg = s;
        lat_cfg   = l;
        push_expected(b, n);
        @(negedge clk);
        w0 = wen_cnt;
        d0 = done_cnt;
        r0 = req_cnt;
        start     = 1'b1;
        base_addr = b;
        count     = c;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 16'($urandom);
        count     = 5'($urandom);
        t0 = cyc - 1;
        check("busy_c1", busy, 32'(n > 0));
        check("req_valid_c1", mem_req_valid, 32'(n > 0));
        seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (glitch && (cyc - t0) == 5) begin
                start     = 1'b1;
                base_addr = 16'h1234;
                count     = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            check("done_cycle", cyc - t0, 1 + n * (s + l + 1));
            check("busy_at_done", busy, 0);
            check("wen_at_done", wen, 32'(n > 0));
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("sb_empty", sb.size(), 0);
        check("wen_count", wen_cnt - w0, n);
        check("done_count", done_cnt - d0, 1);
        if (n == 0) check("no_req_traffic", req_cnt - r0, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int seen;
        int w1;
        int d0;
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;

        // Reset with random inputs, then idle with no start.
        repeat (3) begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            base_addr = 16'($urandom);
            count     = 5'($urandom);
        end
        @(negedge clk);
        check_outputs_zero("reset");
        start    = 1'b0;
        mem_rand = 1'b0;
        rst      = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs_zero("idle");
        req_cnt  = 0;
        wen_cnt  = 0;
        done_cnt = 0;

        // Ideal memory, with an ignored start mid-load.
        run_load(16'h0100, 5'd2, 0, 1, 1'b1);
        // Ready stalls and longer response latency.
        run_load(16'h0100, 5'd2, 3, 4, 1'b0);
        // Count clamp and address wrap.
        run_load(16'hFFFE, 5'd25, 0, 1, 1'b0);
        // Empty load.
        run_load(16'h0300, 5'd0, 0, 1, 1'b0);

        // Reset after the 5th write of a 3-sprite load.
        stall_cfg = 0;
        lat_cfg   = 4;
        push_expected(16'h0400, 18);
        @(negedge clk);
        d0        = done_cnt;
        start     = 1'b1;
        base_addr = 16'h0400;
        count     = 5'd3;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 500; k++) begin
            if (wen === 1'b1) seen++;
            if (seen == 5) break;
            @(negedge clk);
        end
        check("abort_wen5_seen", seen, 5);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort");
        sb.delete();
        exp_addr.delete();
        w1 = wen_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_wen", wen_cnt - w1, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_busy", busy, 0);

        // Fresh load after the aborted one.
        run_load(16'h0500, 5'd1, 0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_position_loader
